// File: rtl/add_sub_seq_if.sv
// -----------------------------------------------------------------------------
// add_sub_seq_if
// Request/response bundle for the sequential adder/subtractor.
//   in_valid/in_ready  : request handshake (producer -> ALU)
//   a, b, sub          : operands and mode (sub=1 -> a-b)
//   out_valid/out_ready: result handshake (ALU -> consumer)
//   s, Z, N, C, V      : result and NZCV flags
// master: the side that issues requests and takes results.
// slave : the add_sub_seq block itself.
// -----------------------------------------------------------------------------
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, Z, N, C, V
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, Z, N, C, V
  );
endinterface

// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
// Multi-cycle adder/subtractor with NZCV flags. Sums CHUNK bits per clock
// through a registered carry, so a result takes WIDTH/CHUNK cycles.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : add_sub_seq_if slave (request in, result out, valid/ready both sides)
// Subtract is A + ~B + 1: B is inverted at capture and the initial carry is 1.
// -----------------------------------------------------------------------------
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  add_sub_seq_if.slave bus
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("add_sub_seq: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("add_sub_seq: CHUNK must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtract
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_s_next;
  logic             w_carry_msb_in;

  // Current chunk's sum, and the full s as it will read after this edge.
  // NOTE: every combinational output gets a default before any conditional
  // write so that no path leaves it unassigned and a latch is inferred.
  always_comb begin
    w_base      = int'(r_idx) * CHUNK;
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_s_next    = r_s;
    w_s_next[w_base +: CHUNK] = w_chunk_sum[CHUNK-1:0];
    // Sum bit = a ^ b ^ cin, so the carry into the top bit falls out of the
    // top bit's operands and result without a second adder.
    w_carry_msb_in = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_s         <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b ^ {WIDTH{bus.sub}};
            r_carry    <= bus.sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_s     <= w_s_next;
          r_carry <= w_chunk_sum[CHUNK];
          if (r_idx == LAST_IDX) begin
            r_c         <= w_chunk_sum[CHUNK];
            r_v         <= w_carry_msb_in ^ w_chunk_sum[CHUNK];
            r_z         <= (w_s_next == '0);
            r_n         <= w_s_next[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DONE: begin
          // Result held until taken; acceptance reopens only on the next edge.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.Z         = r_z;
  assign bus.N         = r_n;
  assign bus.C         = r_c;
  assign bus.V         = r_v;

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
Parametrised multi-cycle adder/subtractor; successor to the fixed 32-bit ripple adder with Z/N flags.
Processes CHUNK bits per clock through a registered carry, so WIDTH and timing trade off.
Adds a subtract mode, full NZCV flags, and valid/ready handshakes on both sides.
Sits between the register-file read stage and writeback as the ALU's add/sub/compare unit.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2).
CHUNK, 8, bits summed per cycle; must divide WIDTH exactly; elaboration error otherwise.
NUM_CHUNKS, WIDTH/CHUNK, derived local parameter; equals the latency in cycles.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  a/b/sub hold a request.
in_ready  out  1  block can accept a request; high only in IDLE.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
sub  in  1  0: A+B; 1: A-B, computed as A + ~B + 1.
out_valid  out  1  s and flags hold a completed result.
out_ready  in  1  consumer takes the result.
s  out  WIDTH  sum or difference, registered.
Z  out  1  s == 0.
N  out  1  s[WIDTH-1].
C  out  1  carry out of the MSB. For subtract, 1 means no borrow (A >= B unsigned).
V  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, out_valid=0, s=0, Z=N=C=V=0, chunk index=0, carry=0. in_ready reads 1 in the cycle after reset is released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1: latch a, latch b XOR {WIDTH{sub}}, set carry=sub, set index=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds chunk [index*CHUNK +: CHUNK] of the latched operands plus the carry, writes that slice of s, and registers the chunk carry-out.
  - On the last chunk (index=NUM_CHUNKS-1): capture the carry into the MSB and the carry out of the MSB, set C and V, set Z and N from the complete s, go to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - s and all flags stay stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - No same-cycle bypass: a new request is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises NUM_CHUNKS edges after the acceptance edge. Throughput is one result per NUM_CHUNKS+2 cycles at best.
- CHUNK=WIDTH degenerates to one RUN cycle with identical results.
- s and flags hold their last values outside DONE. Consumers use them only while out_valid=1.
- Arithmetic is modulo 2^WIDTH. Flags are defined for both the add and subtract paths exactly as in Ports.
- Reset asserted in RUN or DONE aborts the operation: no out_valid pulse, all outputs take their reset values.
- in_valid high during reset is not accepted. The first acceptance is on the first edge with rst=0.

Test Plan:
1. WIDTH=32, CHUNK=8, add 5+3 -> out_valid exactly 4 cycles after acceptance; s=0x00000008, Z=0, N=0, C=0, V=0.
2. sub 7-7 -> s=0, Z=1, N=0, C=1, V=0. sub 3-5 -> s=0xFFFFFFFE, N=1, C=0, V=0.
3. add 0x7FFFFFFF+0x00000001 -> s=0x80000000, N=1, V=1, C=0, Z=0. sub 0x80000000-1 -> s=0x7FFFFFFF, V=1, C=1.
4. add 0xFFFFFFFF+0x00000001 -> carry ripples through all 4 chunks; s=0, Z=1, C=1, V=0.
5. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing a/b -> out_valid stays 1, s and flags unchanged, in_ready=0. Raise out_ready for 1 cycle -> IDLE, in_ready=1, next request accepted.
6. Reset: rst=1 for 1 cycle during RUN (index 2) -> no out_valid, outputs zero, in_ready=1. Then 0x10+0x20 -> s=0x30. Repeat with CHUNK=32 -> latency 1.
